// File: rtl/stopwatch_pkg.sv
// Shared state encodings and default parameter values for the stopwatch lap controller.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_COUNT  = 3'd1,
      ST_LAP    = 3'd2,
      ST_STOP   = 3'd3,
      ST_RECALL = 3'd4
   } sw_state_e;

   localparam int DEF_CNT_W      = 16;
   localparam int DEF_LAP_DEPTH  = 4;
   localparam int DEF_DEB_CYCLES = 4;

   function automatic logic is_running(input sw_state_e s);
      return (s == ST_COUNT) || (s == ST_LAP);
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// Raw switch conditioner: 2-FF synchroniser, run-length debounce, one-cycle rising-edge pulse.
module sw_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_i,
   output logic pulse_o
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          s1_q, s2_q, acc_q, pulse_q;
   logic [CW-1:0] cnt_q;

   // The pulse fires on the same edge the new level is accepted, so a stable rise
   // shows up 2 (sync) + DEB_CYCLES (samples) cycles after it reaches the pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         acc_q   <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q    <= sw_i;
         s2_q    <= s1_q;
         pulse_q <= 1'b0;
         if (s2_q == acc_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            acc_q   <= s2_q;
            cnt_q   <= '0;
            pulse_q <= s2_q;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch with lap memory and recall; three conditioned switches drive a five-state FSM.
// Define STOPWATCH_SAT_EN to make the count saturate and raise a sticky ovf flag.
module stopwatch_lap_ctrl
   import stopwatch_pkg::*;
#(
   parameter  int CNT_W      = DEF_CNT_W,
   parameter  int LAP_DEPTH  = DEF_LAP_DEPTH,
   parameter  int DEB_CYCLES = DEF_DEB_CYCLES,
   localparam int LC_W       = $clog2(LAP_DEPTH + 1),
   localparam int LI_W       = $clog2(LAP_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sw1,
   input  logic             sw2,
   input  logic             sw3,
   input  logic             tick,
   output logic [CNT_W-1:0] count_out,
   output logic [CNT_W-1:0] disp_out,
   output logic [LC_W-1:0]  lap_cnt,
   output logic [LI_W-1:0]  lap_idx,
   output logic             lap_full,
   output logic [2:0]       state_out,
   output logic             ci,
   output logic             ld,
   output logic             clr,
   output logic             ovf
);

   logic [2:0] p_w;

   sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb [2:0] (
      .clk     (clk),
      .rst     (rst),
      .sw_i    ({sw3, sw2, sw1}),
      .pulse_o (p_w)
   );

   // Lap/clear beats start/stop beats recall; losers in the same cycle are dropped.
   logic e1, e2, e3;
   assign e2 = p_w[1];
   assign e1 = p_w[0] & ~p_w[1];
   assign e3 = p_w[2] & ~p_w[0] & ~p_w[1];

   sw_state_e        state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d, frz_q, frz_d, cnt_inc;
   logic [LC_W-1:0]  lap_cnt_q, lap_cnt_d;
   logic [LI_W-1:0]  lap_idx_q, lap_idx_d;
   logic [CNT_W-1:0] lap_mem_q [LAP_DEPTH];
   logic             wr_en, mem_clr, full;

   assign full = (lap_cnt_q == LC_W'(LAP_DEPTH));
   assign ci   = tick & is_running(state_q);

`ifdef STOPWATCH_SAT_EN
   assign cnt_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);
`else
   assign cnt_inc = count_q + CNT_W'(1);
`endif

   always_comb begin
      state_d   = state_q;
      count_d   = ci ? cnt_inc : count_q;
      frz_d     = frz_q;
      lap_cnt_d = lap_cnt_q;
      lap_idx_d = lap_idx_q;
      wr_en     = 1'b0;
      mem_clr   = 1'b0;
      ld        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            count_d = '0;
            if (e1) state_d = ST_COUNT;
         end
         ST_COUNT: begin
            if (e2) begin
               // Freeze the pre-increment value even if a tick lands on this cycle.
               state_d = ST_LAP;
               frz_d   = count_q;
               ld      = 1'b1;
               if (!full) begin
                  wr_en     = 1'b1;
                  lap_cnt_d = lap_cnt_q + LC_W'(1);
               end
            end else if (e1) begin
               state_d = ST_STOP;
            end
         end
         ST_LAP: begin
            if (e2) begin
               state_d = ST_COUNT;
               ld      = 1'b1;
            end else if (e1) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (e2) begin
               state_d   = ST_IDLE;
               count_d   = '0;
               lap_cnt_d = '0;
               lap_idx_d = '0;
               mem_clr   = 1'b1;
            end else if (e1) begin
               state_d = ST_COUNT;
            end else if (e3 && lap_cnt_q != '0) begin
               state_d   = ST_RECALL;
               lap_idx_d = '0;
            end
         end
         ST_RECALL: begin
            if (e2) begin
               state_d = ST_STOP;
            end else if (e3) begin
               ld        = 1'b1;
               lap_idx_d = (LC_W'(lap_idx_q) + LC_W'(1) == lap_cnt_q) ? '0 : lap_idx_q + LI_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         frz_q     <= '0;
         lap_cnt_q <= '0;
         lap_idx_q <= '0;
         for (int i = 0; i < LAP_DEPTH; i++) lap_mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         frz_q     <= frz_d;
         lap_cnt_q <= lap_cnt_d;
         lap_idx_q <= lap_idx_d;
         if (mem_clr) begin
            for (int i = 0; i < LAP_DEPTH; i++) lap_mem_q[i] <= '0;
         end else if (wr_en) begin
            lap_mem_q[LI_W'(lap_cnt_q)] <= count_q;
         end
      end
   end

`ifdef STOPWATCH_SAT_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q | (ci & (count_q == '1));
      if (state_d == ST_IDLE) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   always_comb begin
      unique case (state_q)
         ST_LAP:    disp_out = frz_q;
         ST_RECALL: disp_out = lap_mem_q[lap_idx_q];
         default:   disp_out = count_q;
      endcase
   end

   assign count_out = count_q;
   assign lap_cnt   = lap_cnt_q;
   assign lap_idx   = lap_idx_q;
   assign lap_full  = full;
   assign state_out = state_q;
   assign clr       = (state_q == ST_IDLE);

endmodule
